// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
//   state_t        : main controller FSM states
//   OP_*           : RV32I major opcodes decoded from IR[6:0]
//   ALUOP_*        : ALUOp encodings handed to the ALU decoder
//   RES_*          : ResultSrc mux encodings
//   SRCA_*, SRCB_* : ALU operand mux encodings
//   is_mem_wait    : states that stall on the memory-ready handshake
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    LUI      = 4'd8,
    ALUWB    = 4'd9,
    JALR     = 4'd10,
    JAL      = 4'd11,
    BEQ      = 4'd12,
    ILLEGAL  = 4'd13,
    BUSERR   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic is_mem_wait(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory stall counter with timeout compare.
// Counts consecutive cycles spent in a memory-wait state with mem_ready low.
// The count clears whenever mem_ready is seen or the FSM is not waiting, and
// saturates instead of wrapping.
// Ports:
//   clk, reset : core clock, asynchronous active-high reset
//   waiting    : FSM is in a state that waits on mem_ready
//   mem_ready  : memory handshake
//   timeout    : counter has reached MEM_WAIT_MAX and memory is still not
//                ready this cycle (never asserted when MEM_WAIT_MAX == 0)
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] CNT_MAX = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] CNT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!waiting || mem_ready) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  // A ready response in the limit cycle still wins: timeout needs !mem_ready.
  assign timeout = (MEM_WAIT_MAX > 0) && waiting && !mem_ready && (cnt == CNT_LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Decodes the IR opcode and sequences the shared ALU, register file, unified
// memory port and PC. Outputs are Moore (state only) except IRWrite, PCWrite
// and instr_done in memory states, which qualify on mem_ready.
// Memory handshake: the controller presents an access (fetch, read, or write
// with MemWrite=1) and holds it, unchanged, every cycle until mem_ready=1;
// the cycle with mem_ready=1 is the one in which the access completes.
// Ports:
//   clk, reset    : core clock, asynchronous active-high reset
//   op            : IR[6:0], stable from DECODE until the next fetch completes
//   mem_ready     : memory accepts write / returns read data this cycle
//   branch_cond   : branch comparison, valid in BEQ
//   PCWrite .. ALUOp : datapath enables and mux selects
//   instr_done    : one-cycle pulse on the last cycle of a retired instruction
//   illegal_instr : high in ILLEGAL (terminal until reset)
//   bus_error     : high in BUSERR (terminal until reset)
//   dbg_state     : current FSM state for observation
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       branch_cond,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       bus_error,
  output state_t     dbg_state
);

  state_t state, next_state;
  logic   timeout;

  // Raw (ungated) strobes; reset gating is applied at the output.
  logic pc_update, branch, ir_write, reg_write, mem_write, done;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .waiting  (is_mem_wait(state)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUOp      = ALUOP_ADD;

    case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = mem_ready;
        pc_update = mem_ready;
        if (mem_ready)    next_state = DECODE;
        else if (timeout) next_state = BUSERR;
      end
      DECODE: begin
        // Precompute PC+imm into ALUOut for branch/JAL/AUIPC.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECUTER;
          OP_ITYPE:          next_state = EXECUTEI;
          OP_BRANCH:         next_state = BEQ;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
          OP_LUI:            next_state = LUI;
          OP_AUIPC:          next_state = ALUWB;
          default:           next_state = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready)    next_state = MEMWB;
        else if (timeout) next_state = BUSERR;
      end
      MEMWB: begin
        ResultSrc  = RES_READDATA;
        reg_write  = 1'b1;
        done       = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = mem_ready;
        if (mem_ready)    next_state = FETCH;
        else if (timeout) next_state = BUSERR;
      end
      EXECUTER: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        next_state = FETCH;
      end
      JALR: begin
        // rs1+imm lands in ALUOut; JAL then moves it into the PC.
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        next_state = JAL;
      end
      JAL: begin
        // PC <- ALUOut (target) while ALU computes OldPC+4 for the link.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_SUB;
        branch     = 1'b1;
        done       = 1'b1;
        next_state = FETCH;
      end
      ILLEGAL: next_state = ILLEGAL;
      BUSERR:  next_state = BUSERR;
      default: next_state = FETCH;
    endcase
  end

  // Enables and flags are forced low asynchronously while reset is held, so a
  // reset mid-write drops MemWrite without waiting for a clock edge.
  assign PCWrite       = !reset && (pc_update || (branch && branch_cond));
  assign IRWrite       = !reset && ir_write;
  assign RegWrite      = !reset && reg_write;
  assign MemWrite      = !reset && mem_write;
  assign instr_done    = !reset && done;
  assign illegal_instr = !reset && (state == ILLEGAL);
  assign bus_error     = !reset && (state == BUSERR);
  assign dbg_state     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import cpu_ctrl_pkg::*;

  localparam int W = 20;  // {state[3:0], 16 output bits}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [6:0] op;
  logic       mem_ready, branch_cond;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal_instr, bus_error;
  state_t     dbg_state;

  multicycle_controller #(.MEM_WAIT_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .mem_ready    (mem_ready),
    .branch_cond  (branch_cond),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int passed = 0;

  function automatic logic [15:0] ov(
    input logic pcw, input logic adr, input logic irw, input logic rw, input logic mw,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
    input logic dn, input logic ill, input logic be);
    return {pcw, adr, irw, rw, mw, rs, sa, sb, aop, dn, ill, be};
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] e, o;
    o = {dbg_state, PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ResultSrc,
         ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_instr, bus_error};
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) begin
        passed++;
      end else begin
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives this cycle's inputs, checks at negedge,
  // returns at the following posedge+1.
  task automatic step(input string tag, input logic mr, input logic [6:0] o,
                      input logic bc, input state_t st, input logic [15:0] v);
    mem_ready   = mr;
    op          = o;
    branch_cond = bc;
    exp_q.push_back({st, v});
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  // Expected output vectors, written directly from the state table.
  logic [15:0] v_fetch_r, v_fetch_n, v_rst, v_decode, v_exr, v_exi, v_aluwb;
  logic [15:0] v_memadr, v_memrd, v_memwb, v_memwr_n, v_memwr_r;
  logic [15:0] v_beq1, v_beq0, v_jalr, v_jal, v_lui, v_ill, v_buserr;

  // ---------------- directed sequence ----------------
  initial begin
    v_fetch_r = ov(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0);
    v_fetch_n = ov(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0);
    v_rst     = v_fetch_n;
    v_decode  = ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0);
    v_exr     = ov(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0);
    v_exi     = ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,0);
    v_aluwb   = ov(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
    v_memadr  = ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0);
    v_memrd   = ov(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    v_memwb   = ov(0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,1,0,0);
    v_memwr_n = ov(0,1,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0,0);
    v_memwr_r = ov(0,1,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0,0);
    v_beq1    = ov(1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,1,0,0);
    v_beq0    = ov(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,1,0,0);
    v_jalr    = ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0);
    v_jal     = ov(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0);
    v_lui     = ov(0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0,0,0);
    v_ill     = ov(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0);
    v_buserr  = ov(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1);

    // Reset held with mem_ready high: FETCH, but IRWrite/PCWrite forced low.
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0; branch_cond = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back({FETCH, v_rst});
    check("reset_hold");
    @(posedge clk); #1;
    reset = 1'b0;

    // add: 4 cycles, RegWrite/instr_done only in the last.
    step("add_fetch",  1, OP_RTYPE, 0, FETCH,    v_fetch_r);
    step("add_decode", 1, OP_RTYPE, 0, DECODE,   v_decode);
    step("add_exec",   1, OP_RTYPE, 0, EXECUTER, v_exr);
    step("add_wb",     1, OP_RTYPE, 0, ALUWB,    v_aluwb);

    // addi
    step("addi_fetch",  1, OP_ITYPE, 0, FETCH,    v_fetch_r);
    step("addi_decode", 1, OP_ITYPE, 0, DECODE,   v_decode);
    step("addi_exec",   1, OP_ITYPE, 0, EXECUTEI, v_exi);
    step("addi_wb",     1, OP_ITYPE, 0, ALUWB,    v_aluwb);

    // lw with 3 stall cycles in MEMREAD: 8 cycles total.
    step("lw_fetch",  1, OP_LOAD, 0, FETCH,  v_fetch_r);
    step("lw_decode", 1, OP_LOAD, 0, DECODE, v_decode);
    step("lw_adr",    1, OP_LOAD, 0, MEMADR, v_memadr);
    for (int i = 0; i < 3; i++) step("lw_stall", 0, OP_LOAD, 0, MEMREAD, v_memrd);
    step("lw_rd",     1, OP_LOAD, 0, MEMREAD, v_memrd);
    step("lw_wb",     1, OP_LOAD, 0, MEMWB,   v_memwb);

    // lw with 4 stalls: ready arrives exactly at the timeout limit and wins.
    step("lw4_fetch",  1, OP_LOAD, 0, FETCH,  v_fetch_r);
    step("lw4_decode", 1, OP_LOAD, 0, DECODE, v_decode);
    step("lw4_adr",    1, OP_LOAD, 0, MEMADR, v_memadr);
    for (int i = 0; i < 4; i++) step("lw4_stall", 0, OP_LOAD, 0, MEMREAD, v_memrd);
    step("lw4_rd_limit", 1, OP_LOAD, 0, MEMREAD, v_memrd);
    step("lw4_wb",       1, OP_LOAD, 0, MEMWB,   v_memwb);

    // sw with one stall: MemWrite held, instr_done only with mem_ready.
    step("sw_fetch",  1, OP_STORE, 0, FETCH,    v_fetch_r);
    step("sw_decode", 1, OP_STORE, 0, DECODE,   v_decode);
    step("sw_adr",    1, OP_STORE, 0, MEMADR,   v_memadr);
    step("sw_stall",  0, OP_STORE, 0, MEMWRITE, v_memwr_n);
    step("sw_done",   1, OP_STORE, 0, MEMWRITE, v_memwr_r);

    // beq taken / not taken.
    step("beq1_fetch",  1, OP_BRANCH, 1, FETCH,  v_fetch_r);
    step("beq1_decode", 1, OP_BRANCH, 1, DECODE, v_decode);
    step("beq1_taken",  1, OP_BRANCH, 1, BEQ,    v_beq1);
    step("beq0_fetch",  1, OP_BRANCH, 0, FETCH,  v_fetch_r);
    step("beq0_decode", 1, OP_BRANCH, 0, DECODE, v_decode);
    step("beq0_nottkn", 1, OP_BRANCH, 0, BEQ,    v_beq0);

    // jal, jalr
    step("jal_fetch",   1, OP_JAL,  0, FETCH,  v_fetch_r);
    step("jal_decode",  1, OP_JAL,  0, DECODE, v_decode);
    step("jal_jal",     1, OP_JAL,  0, JAL,    v_jal);
    step("jal_wb",      1, OP_JAL,  0, ALUWB,  v_aluwb);
    step("jalr_fetch",  1, OP_JALR, 0, FETCH,  v_fetch_r);
    step("jalr_decode", 1, OP_JALR, 0, DECODE, v_decode);
    step("jalr_jalr",   1, OP_JALR, 0, JALR,   v_jalr);
    step("jalr_jal",    1, OP_JALR, 0, JAL,    v_jal);
    step("jalr_wb",     1, OP_JALR, 0, ALUWB,  v_aluwb);

    // lui, auipc
    step("lui_fetch",    1, OP_LUI,   0, FETCH,  v_fetch_r);
    step("lui_decode",   1, OP_LUI,   0, DECODE, v_decode);
    step("lui_lui",      1, OP_LUI,   0, LUI,    v_lui);
    step("lui_wb",       1, OP_LUI,   0, ALUWB,  v_aluwb);
    step("auipc_fetch",  1, OP_AUIPC, 0, FETCH,  v_fetch_r);
    step("auipc_decode", 1, OP_AUIPC, 0, DECODE, v_decode);
    step("auipc_wb",     1, OP_AUIPC, 0, ALUWB,  v_aluwb);

    // Fetch stalls (random 1..3, below the limit), then a stalled store
    // interrupted by reset.
    for (int i = 0, n = $urandom_range(3, 1); i < n; i++)
      step("fetch_stall", 0, OP_STORE, 0, FETCH, v_fetch_n);
    step("rsw_fetch",  1, OP_STORE, 0, FETCH,    v_fetch_r);
    step("rsw_decode", 1, OP_STORE, 0, DECODE,   v_decode);
    step("rsw_adr",    1, OP_STORE, 0, MEMADR,   v_memadr);
    step("rsw_stall",  0, OP_STORE, 0, MEMWRITE, v_memwr_n);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back({FETCH, v_rst});
    check("rst_mid_write_async");
    mem_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back({FETCH, v_rst});
    check("rst_mid_write_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    step("post_rst_fetch",  1, OP_STORE, 0, FETCH,    v_fetch_r);
    step("post_rst_decode", 1, OP_STORE, 0, DECODE,   v_decode);
    step("post_rst_adr",    1, OP_STORE, 0, MEMADR,   v_memadr);
    step("post_rst_done",   1, OP_STORE, 0, MEMWRITE, v_memwr_r);

    // Illegal opcode: terminal until reset.
    step("ill_fetch",  1, 7'b0000000, 0, FETCH,  v_fetch_r);
    step("ill_decode", 1, 7'b0000000, 0, DECODE, v_decode);
    for (int i = 0; i < 3; i++)
      step("ill_hold", 1'($urandom_range(1, 0)), 7'b0000000, 0, ILLEGAL, v_ill);

    // Reset, then fetch never ready: 5 FETCH cycles then BUSERR.
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    exp_q.push_back({FETCH, v_rst});
    check("ill_cleared_by_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("to_fetch_wait", 0, OP_RTYPE, 0, FETCH, v_fetch_n);
    step("buserr",      0, OP_RTYPE, 0, BUSERR, v_buserr);
    step("buserr_hold", 1, OP_RTYPE, 0, BUSERR, v_buserr);

    // Recover via reset.
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step("recover_fetch", 1, OP_RTYPE, 0, FETCH,  v_fetch_r);
    step("recover_dec",   1, OP_RTYPE, 0, DECODE, v_decode);

    if (exp_q.size() != 0) begin
      total++;
      $error("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
